ctrl_seq: RTL

Parametrised successor to the VeriRISC instruction-cycle controller. It sequences fetch, decode, execute and store for the accumulator CPU like the existing 8-state controller. It also adds a memory ready handshake with bounded wait, a fault state on memory timeout, a resumable halt, single-step mode, and a retired-instruction counter. It sits between the instruction register/opcode decode and the memory, PC and accumulator load strobes.

---
 rtl/ctrl_seq_pkg.sv | 47 ++++
 rtl/wait_timer.sv | 32 +++
 rtl/ctrl_seq.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/ctrl_seq_pkg.sv
// Shared typedefs for the accumulator CPU instruction-cycle controller.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package ctrl_seq_pkg;

   typedef enum logic [2:0] {
      HLT = 3'd0,
      SKZ = 3'd1,
      ADD = 3'd2,
      AND = 3'd3,
      XOR = 3'd4,
      LDA = 3'd5,
      STO = 3'd6,
      JMP = 3'd7
   } opcode_t;

   typedef enum logic [3:0] {
      INST_ADDR,
      INST_FETCH,
      INST_LOAD,
      IDLE,
      OP_ADDR,
      OP_FETCH,
      ALU_OP,
      STORE,
      HALTED,
      PAUSED,
      FAULT
   } ctrl_state_t;

   typedef struct packed {
      logic mem_rd;
      logic mem_wr;
      logic load_ir;
      logic load_ac;
      logic load_pc;
      logic inc_pc;
      logic halt;
      logic fault;
   } ctrl_out_t;

   // Opcodes that read an operand from memory and load the accumulator.
   function automatic logic is_aluop(input opcode_t op);
      return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
   endfunction

endpackage

// File: rtl/wait_timer.sv
// Bounded wait counter for memory handshakes; expired flags the last allowed cycle.
// Latency: counter updates one edge after count; expired is combinational from the count.
// Backpressure: none; the count saturates at MAX_WAIT until cleared.
//
// Ports: clk, rst_ (async active-low), clear (zero the count),
//        count (advance by one), expired (count has reached MAX_WAIT).
module wait_timer #(
   parameter int MAX_WAIT = 15,
   parameter int WAIT_W   = 4
) (
   input  logic clk,
   input  logic rst_,
   input  logic clear,
   input  logic count,
   output logic expired
);

   logic [WAIT_W-1:0] r_wait_cnt;

   assign expired = (r_wait_cnt == WAIT_W'(MAX_WAIT));

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         r_wait_cnt <= '0;
      end else if (clear) begin
         r_wait_cnt <= '0;
      end else if (count && !expired) begin
         r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
      end
   end

endmodule

// File: rtl/ctrl_seq.sv
// Instruction-cycle sequencer with memory-ready waits, timeout fault, halt/resume, single-step.
// Latency: 8 cycles per instruction with immediate acks; each missing ack adds one cycle.
// Backpressure: waits on mem_ack in fetch/operand/store states, faults after MAX_WAIT extra cycles.
//
// Ports: clk, rst_ (async active-low); opcode, zero (decode inputs); mem_ack (memory done);
//        resume/step (pulses leaving HALTED/PAUSED); step_mode (pause after each instruction);
//        mem_rd, mem_wr, load_ir, load_ac, load_pc, inc_pc (registered strobes);
//        halt, fault (status); instr_cnt (retired-instruction count, wrapping).
module ctrl_seq
   import ctrl_seq_pkg::*;
#(
   parameter int MAX_WAIT = 15,
   parameter int WAIT_W   = 4,
   parameter int CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst_,
   input  opcode_t          opcode,
   input  logic             zero,
   input  logic             mem_ack,
   input  logic             resume,
   input  logic             step_mode,
   input  logic             step,
   output logic             mem_rd,
   output logic             mem_wr,
   output logic             load_ir,
   output logic             load_ac,
   output logic             load_pc,
   output logic             inc_pc,
   output logic             halt,
   output logic             fault,
   output logic [CNT_W-1:0] instr_cnt
);

   ctrl_state_t      r_state;
   ctrl_state_t      w_nstate;
   ctrl_out_t        r_out;
   ctrl_out_t        w_out;
   logic [CNT_W-1:0] r_instr_cnt;
   logic             w_aluop;
   logic             w_in_wait;
   logic             w_expired;
   logic             w_retire;

   assign w_aluop = is_aluop(opcode);

   // Operand fetch only waits for ALU ops, store only waits for STO.
   assign w_in_wait = (r_state == INST_FETCH)
                   || ((r_state == OP_FETCH) && w_aluop)
                   || ((r_state == STORE) && (opcode == STO));

   // Every path into a wait state passes through a non-wait state, so
   // clearing outside waits gives a fresh count on each entry.
   wait_timer #(
      .MAX_WAIT (MAX_WAIT),
      .WAIT_W   (WAIT_W)
   ) u_wait_timer (
      .clk     (clk),
      .rst_    (rst_),
      .clear   (!w_in_wait),
      .count   (w_in_wait && !mem_ack),
      .expired (w_expired)
   );

   // Next state; an ack is checked before the timeout so ack wins a tie.
   always_comb begin
      w_nstate = r_state;
      w_retire = 1'b0;
      case (r_state)
         INST_ADDR:  w_nstate = INST_FETCH;
         INST_FETCH: begin
            if (mem_ack)        w_nstate = INST_LOAD;
            else if (w_expired) w_nstate = FAULT;
         end
         INST_LOAD:  w_nstate = IDLE;
         IDLE:       w_nstate = OP_ADDR;
         OP_ADDR: begin
            if (opcode == HLT) begin
               w_nstate = HALTED;
               w_retire = 1'b1;
            end else begin
               w_nstate = OP_FETCH;
            end
         end
         OP_FETCH: begin
            if (!w_aluop || mem_ack) w_nstate = ALU_OP;
            else if (w_expired)      w_nstate = FAULT;
         end
         ALU_OP:     w_nstate = STORE;
         STORE: begin
            if ((opcode != STO) || mem_ack) begin
               w_nstate = step_mode ? PAUSED : INST_ADDR;
               w_retire = 1'b1;
            end else if (w_expired) begin
               w_nstate = FAULT;
            end
         end
         HALTED:     if (resume) w_nstate = INST_ADDR;
         PAUSED:     if (step)   w_nstate = INST_ADDR;
         FAULT:      w_nstate = FAULT;
         default:    w_nstate = INST_ADDR;
      endcase
   end

   // Moore decode of the state being entered, registered below.
   always_comb begin
      w_out = '0;
      case (w_nstate)
         INST_FETCH: w_out.mem_rd = 1'b1;
         INST_LOAD, IDLE: begin
            w_out.mem_rd  = 1'b1;
            w_out.load_ir = 1'b1;
         end
         OP_ADDR:    w_out.inc_pc = 1'b1;
         OP_FETCH:   w_out.mem_rd = w_aluop;
         ALU_OP: begin
            w_out.mem_rd  = w_aluop;
            w_out.load_ac = w_aluop;
            w_out.inc_pc  = (opcode == SKZ) && zero;
            w_out.load_pc = (opcode == JMP);
         end
         STORE: begin
            w_out.mem_wr  = (opcode == STO);
            w_out.load_pc = (opcode == JMP);
            w_out.inc_pc  = (opcode == JMP);
         end
         HALTED, PAUSED: w_out.halt = 1'b1;
         FAULT: begin
            w_out.halt  = 1'b1;
            w_out.fault = 1'b1;
         end
         default: w_out = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         r_state     <= INST_ADDR;
         r_out       <= '0;
         r_instr_cnt <= '0;
      end else begin
         r_state <= w_nstate;
         r_out   <= w_out;
         if (w_retire) r_instr_cnt <= r_instr_cnt + CNT_W'(1);
      end
   end

   assign mem_rd    = r_out.mem_rd;
   assign mem_wr    = r_out.mem_wr;
   assign load_ir   = r_out.load_ir;
   assign load_ac   = r_out.load_ac;
   assign load_pc   = r_out.load_pc;
   assign inc_pc    = r_out.inc_pc;
   assign halt      = r_out.halt;
   assign fault     = r_out.fault;
   assign instr_cnt = r_instr_cnt;

endmodule
